// File: rtl/ram_sequencer_if.sv
// rtl/ram_sequencer_if.sv - request/response port bundle of the SRAM register sequencer
//
// Purpose: groups the single-word valid/ready request channel and the
// one-cycle response pulse that connect a bus master to ram_sequencer.
// Signals:
//   req_valid  master->seq  request present
//   req_ready  seq->master  request accepted on an edge with req_valid
//   req_write  master->seq  1=write, 0=read
//   req_addr   master->seq  16-bit word address
//   req_wdata  master->seq  16-bit write data
//   req_be     master->seq  byte enables {ub,lb}, ignored for reads
//   rsp_valid  seq->master  one-cycle completion pulse
//   rsp_rdata  seq->master  read data (16'h0000 for writes)
interface ram_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_sequencer.sv
// rtl/ram_sequencer.sv - expands single-word requests into SRAM MAR/MDR/strobe sequences
//
// Purpose: bus-side initiator for an SRAM block exposing a MAR/MDR register
// pair plus read/write strobes. Each accepted request becomes the
// MAR-load / MDR-load / strobe sequence; byte-masked writes are done as
// read-modify-write because the SRAM byte lanes are always enabled.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   bus           request/response channel (ram_sequencer_if.slave)
//   reg_load_ub   load upper byte of the selected register
//   reg_load_lb   load lower byte of the selected register
//   reg_sel       1=MAR, 0=MDR
//   read          SRAM read strobe (MDR captures SRAM data each edge)
//   write         SRAM write strobe (MDR driven onto SRAM)
//   reg_d         data to the selected register
//   reg_q         contents of the selected register
module ram_sequencer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_sequencer_if.slave    bus,
  output logic              reg_load_ub,
  output logic              reg_load_lb,
  output logic              reg_sel,
  output logic              read,
  output logic              write,
  output logic [15:0]       reg_d,
  input  logic [15:0]       reg_q
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LD_MAR = 3'd1;
  localparam logic [2:0] RD_ACC = 3'd2;
  localparam logic [2:0] RD_CAP = 3'd3;
  localparam logic [2:0] LD_MDR = 3'd4;
  localparam logic [2:0] WR_ACC = 3'd5;
  localparam logic [2:0] WR_REC = 3'd6;
  localparam logic [2:0] RESP   = 3'd7;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // Latched request fields; the address lives in MAR after LD_MAR, so it
  // never needs a private copy.
  logic          cap_write;
  logic [15:0]   cap_wdata;
  logic [1:0]    cap_be;

  logic          accept;
  assign accept = bus.req_valid & bus.req_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          // A write with no lanes enabled has nothing to touch in the SRAM.
          if (bus.req_write && bus.req_be == 2'b00) state_nx = RESP;
          else                                      state_nx = LD_MAR;
        end
      end
      LD_MAR: begin
        if (cap_write && cap_be == 2'b11) begin
          state_nx = LD_MDR;
        end else begin
          state_nx = RD_ACC;
          cnt_nx   = CNT_LOAD;
        end
      end
      RD_ACC: begin
        if (cnt == '0) state_nx = cap_write ? LD_MDR : RD_CAP;
        else           cnt_nx   = cnt - 1'b1;
      end
      RD_CAP: state_nx = RESP;
      LD_MDR: begin
        state_nx = WR_ACC;
        cnt_nx   = CNT_LOAD;
      end
      WR_ACC: begin
        if (cnt == '0) state_nx = WR_REC;
        else           cnt_nx   = cnt - 1'b1;
      end
      WR_REC: state_nx = RESP;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Every SRAM-side control is a flop decoded from the next state, so the
  // outputs seen during a cycle belong to the state of that cycle and are
  // free of decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_write     <= 1'b0;
      cap_wdata     <= 16'h0000;
      cap_be        <= 2'b00;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 16'h0000;
      reg_load_ub   <= 1'b0;
      reg_load_lb   <= 1'b0;
      reg_sel       <= 1'b0;
      read          <= 1'b0;
      write         <= 1'b0;
      reg_d         <= 16'h0000;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;

      if (accept) begin
        cap_write <= bus.req_write;
        cap_wdata <= bus.req_wdata;
        cap_be    <= bus.req_be;
      end

      bus.req_ready <= (state_nx == IDLE);
      bus.rsp_valid <= (state_nx == RESP);

      reg_sel     <= (state_nx == LD_MAR);
      reg_load_ub <= (state_nx == LD_MAR) || (state_nx == LD_MDR && cap_be[1]);
      reg_load_lb <= (state_nx == LD_MAR) || (state_nx == LD_MDR && cap_be[0]);
      read        <= (state_nx == RD_ACC);
      write       <= (state_nx == WR_ACC);

      // LD_MAR is only ever entered from IDLE, so the address is still on
      // the request port at that edge.
      if (state_nx == LD_MAR)      reg_d <= bus.req_addr;
      else if (state_nx == LD_MDR) reg_d <= cap_wdata;
      else                         reg_d <= 16'h0000;

      // MDR is selected during RD_CAP and holds the word captured by the
      // last read edge.
      if (state == RD_CAP) bus.rsp_rdata <= reg_q;
      else if (accept)     bus.rsp_rdata <= 16'h0000;
    end
  end

endmodule
